// File: rtl/tb_uart_rx_mon.sv
// tb_uart_rx_mon
// Bench-side UART receiver. It watches the SoC UART TX pad and decodes
// 8N1 frames, or 8E1/8O1 frames when PARITY_EN is set, LSB first. Decoded
// bytes go into a small FIFO and are handed to the bench over valid/ready.
// Framing, parity and overflow problems are reported so that a silent or
// corrupt print path fails the test.
//
// Ports
//   sys_clk     bench clock
//   sys_rst     synchronous reset, active high
//   rx_i        serial line (asynchronous, idles high)
//   byte_o      FIFO head byte (0 while the FIFO is empty)
//   byte_vld_o  FIFO not empty
//   byte_rdy_i  consumer takes byte_o when byte_vld_o && byte_rdy_i
//   frm_err_o   1-cycle pulse: stop bit sampled low
//   par_err_o   1-cycle pulse: parity mismatch
//   ovf_o       sticky: a byte was dropped because the FIFO was full
//   err_cnt_o   saturating count of framing, parity and overflow events
//   busy_o      receiver is inside a frame (state != IDLE)
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | line idle, waiting for a falling edge
// START    | half-bit wait, then recheck the start bit
// DATA     | sampling 8 data bits at mid-bit
// PARITY   | sampling the parity bit
// STOP     | sampling the stop bit, then push or report the error
// BRK_WAIT | stop bit was low; wait for the line to return high

module tb_uart_rx_mon #(
    parameter int CLK_DIV    = 140,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        rx_i,
    output logic [7:0]  byte_o,
    output logic        byte_vld_o,
    input  logic        byte_rdy_i,
    output logic        frm_err_o,
    output logic        par_err_o,
    output logic        ovf_o,
    output logic [15:0] err_cnt_o,
    output logic        busy_o
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLK_DIV >> 1) - 1);
    localparam logic USE_PAR = (PARITY_EN != 0);
    localparam logic ODD_PAR = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
    } state_t;

    logic             rx_m, rx_s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             par_bad, par_bad_nxt;
    logic             tc;
    logic             push, frm_evt, par_evt;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, pop, wr_en, drop, err_evt;

    assign tc = (cnt == '0);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = tc ? cnt : cnt - 1'b1;
        idx_nxt     = idx;
        shreg_nxt   = shreg;
        par_bad_nxt = par_bad;
        push        = 1'b0;
        frm_evt     = 1'b0;
        par_evt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nxt   = S_START;
                    cnt_nxt     = CNT_HALF;
                    par_bad_nxt = 1'b0;
                end
            end
            S_START: begin
                if (tc) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (!rx_s) begin
                        state_nxt = S_DATA;
                        cnt_nxt   = CNT_FULL;
                        idx_nxt   = 3'd0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tc) begin
                    shreg_nxt[idx] = rx_s;
                    cnt_nxt        = CNT_FULL;
                    if (idx == 3'd7) begin
                        state_nxt = USE_PAR ? S_PARITY : S_STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tc) begin
                    // Even parity bit equals the XOR of the data bits.
                    par_bad_nxt = (rx_s != ((^shreg) ^ ODD_PAR));
                    cnt_nxt     = CNT_FULL;
                    state_nxt   = S_STOP;
                end
            end
            S_STOP: begin
                if (tc) begin
                    if (rx_s) begin
                        if (par_bad) par_evt = 1'b1;
                        else         push    = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        frm_evt   = 1'b1;
                        state_nxt = S_BRK_WAIT;
                    end
                end
            end
            S_BRK_WAIT: begin
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= 3'd0;
            shreg   <= 8'h00;
            par_bad <= 1'b0;
        end else begin
            rx_m    <= rx_i;
            rx_s    <= rx_m;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shreg   <= shreg_nxt;
            par_bad <= par_bad_nxt;
        end
    end

    // The extra pointer MSB separates full from empty.
    assign byte_vld_o = (wr_ptr != rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = byte_vld_o && byte_rdy_i;
    // When full, a same-cycle pop frees the slot being written.
    assign wr_en      = push && (!full || pop);
    assign drop       = push && full && !pop;
    assign err_evt    = frm_evt || par_evt || drop;
    assign byte_o     = byte_vld_o ? mem[rd_ptr[AW-1:0]] : 8'h00;
    assign busy_o     = (state != S_IDLE);

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frm_err_o <= 1'b0;
            par_err_o <= 1'b0;
            ovf_o     <= 1'b0;
            err_cnt_o <= 16'h0000;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            frm_err_o <= frm_evt;
            par_err_o <= par_evt;
            if (drop) ovf_o <= 1'b1;
            if (err_evt && (err_cnt_o != 16'hFFFF)) err_cnt_o <= err_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_tb_uart_rx_mon.sv
// tb_tb_uart_rx_mon
// Self-checking bench for tb_uart_rx_mon. Instance A: CLK_DIV 140, no parity.
// Instance B: CLK_DIV 16, even parity. Frames are driven bit by bit. The
// expected byte stream, error counts and overflow flag come from a queue
// model built from frame-level rules.

module tb_tb_uart_rx_mon;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        rx_a = 1'b1, rdy_a = 1'b0, rx_b = 1'b1, rdy_b = 1'b0;
    logic [7:0]  byte_a, byte_b;
    logic        vld_a, vld_b, frm_a, frm_b, par_a, par_b, ovf_a, ovf_b, busy_a, busy_b;
    logic [15:0] errc_a, errc_b;

    always #5 sys_clk = ~sys_clk;

    tb_uart_rx_mon #(.CLK_DIV(140), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_i(rx_a),
        .byte_o(byte_a), .byte_vld_o(vld_a), .byte_rdy_i(rdy_a),
        .frm_err_o(frm_a), .par_err_o(par_a), .ovf_o(ovf_a),
        .err_cnt_o(errc_a), .busy_o(busy_a));

    tb_uart_rx_mon #(.CLK_DIV(16), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_i(rx_b),
        .byte_o(byte_b), .byte_vld_o(vld_b), .byte_rdy_i(rdy_b),
        .frm_err_o(frm_b), .par_err_o(par_b), .ovf_o(ovf_b),
        .err_cnt_o(errc_b), .busy_o(busy_b));

    int n_chk = 0, n_pass = 0;

    // model state
    logic [7:0] qa[$], qb[$];
    int exp_err_a = 0, exp_err_b = 0, exp_frm_a = 0, exp_frm_b = 0, exp_par_b = 0;
    logic exp_ovf_a = 1'b0, exp_ovf_b = 1'b0;

    // observations (written only by the monitor)
    logic [7:0] got_a[$], got_b[$];
    int nfrm_a = 0, nfrm_b = 0, npar_a = 0, npar_b = 0, nbusy_a = 0;

    always @(negedge sys_clk) begin
        if (!sys_rst && vld_a && rdy_a) got_a.push_back(byte_a);
        if (!sys_rst && vld_b && rdy_b) got_b.push_back(byte_b);
        if (frm_a) nfrm_a++;
        if (frm_b) nfrm_b++;
        if (par_a) npar_a++;
        if (par_b) npar_b++;
        if (busy_a) nbusy_a++;
    end

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(int sel, logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // Frame-level model: a good frame is stored if the FIFO has room
    // (pushed minus already handed over), otherwise it is an overflow.
    task automatic model_push(int sel, logic [7:0] d);
        if (sel == 0) begin
            if (qa.size() - got_a.size() >= 4) begin exp_err_a++; exp_ovf_a = 1'b1; end
            else qa.push_back(d);
        end else begin
            if (qb.size() - got_b.size() >= 4) begin exp_err_b++; exp_ovf_b = 1'b1; end
            else qb.push_back(d);
        end
    endtask

    // Leaves the line at the stop-bit level when it returns.
    task automatic send(int sel, logic [7:0] d, logic par_ok, logic stop, logic jit);
        int div;
        int j;
        div = (sel == 0) ? 140 : 16;
        for (int b = 0; b < 11; b++) begin
            j = jit ? int'($urandom_range(0, 4)) - 2 : 0;
            if (b == 0) drive(sel, 1'b0);
            else if (b <= 8) drive(sel, d[b-1]);
            else if (b == 9) begin
                if (sel == 0) continue;
                drive(sel, par_ok ? (^d) : ~(^d));
            end else begin
                if (!stop) begin
                    if (sel == 0) begin exp_frm_a++; exp_err_a++; end
                    else          begin exp_frm_b++; exp_err_b++; end
                end else if (sel == 1 && !par_ok) begin
                    exp_par_b++; exp_err_b++;
                end else begin
                    model_push(sel, d);
                end
                drive(sel, stop);
            end
            tick(div + j);
        end
    endtask

    task automatic drain(int sel, string tag);
        logic [7:0] g;
        if (sel == 0) begin
            while (got_a.size() > 0) begin
                g = got_a.pop_front();
                if (qa.size() == 0) check_val({tag, "_extra"}, {24'h0, g}, 32'hDEAD);
                else check_val(tag, {24'h0, g}, {24'h0, qa.pop_front()});
            end
            check_val({tag, "_missing"}, qa.size(), 0);
        end else begin
            while (got_b.size() > 0) begin
                g = got_b.pop_front();
                if (qb.size() == 0) check_val({tag, "_extra"}, {24'h0, g}, 32'hDEAD);
                else check_val(tag, {24'h0, g}, {24'h0, qb.pop_front()});
            end
            check_val({tag, "_missing"}, qb.size(), 0);
        end
    endtask

    task automatic reset_dut();
        sys_rst = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        qa.delete(); qb.delete(); got_a.delete(); got_b.delete();
        exp_err_a = 0; exp_err_b = 0; exp_ovf_a = 1'b0; exp_ovf_b = 1'b0;
    endtask

    initial begin
        int b0;
        logic [7:0] d;
        logic st, pk;

        reset_dut();
        check_val("rst_byte", byte_a, 0);
        check_val("rst_vld", vld_a, 0);
        check_val("rst_frm", frm_a, 0);
        check_val("rst_par", par_a, 0);
        check_val("rst_ovf", ovf_a, 0);
        check_val("rst_err", errc_a, 0);
        check_val("rst_busy", busy_a, 0);
        check_val("rst_busy_b", busy_b, 0);

        // single byte, measure busy time: half bit + 8 data bits + stop
        rdy_a = 1'b1;
        b0 = nbusy_a;
        send(0, 8'h55, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1);
        tick(140);
        check_val("t1_busy_cycles", nbusy_a - b0, 1330);
        drain(0, "t1_byte");
        check_val("t1_err", errc_a, 0);

        // two bytes held, then popped in order
        rdy_a = 1'b0;
        send(0, 8'h41, 1'b1, 1'b1, 1'b0);
        send(0, 8'h0A, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1);
        tick(20);
        check_val("t2_vld_held", vld_a, 1);
        check_val("t2_head", byte_a, 8'h41);
        rdy_a = 1'b1;
        tick(5);
        drain(0, "t2_order");
        check_val("t2_vld_after", vld_a, 0);

        // 50-cycle glitch: START lasts a half bit, then rejects
        b0 = nbusy_a;
        drive(0, 1'b0);
        tick(50);
        drive(0, 1'b1);
        tick(300);
        check_val("t3_busy_cycles", nbusy_a - b0, 70);
        check_val("t3_busy", busy_a, 0);
        check_val("t3_err", errc_a, 0);
        check_val("t3_frm", nfrm_a, exp_frm_a);
        drain(0, "t3_none");

        // framing error then line held low
        reset_dut();
        send(0, 8'hA3, 1'b1, 1'b0, 1'b0);
        tick(3000);
        check_val("t4_brk_busy", busy_a, 1);
        check_val("t4_frm_cnt", nfrm_a, exp_frm_a);
        check_val("t4_err", errc_a, exp_err_a);
        check_val("t4_vld", vld_a, 0);
        drive(0, 1'b1);
        tick(10);
        check_val("t4_idle", busy_a, 0);
        tick(200);
        check_val("t4_frm_final", nfrm_a, exp_frm_a);
        drain(0, "t4_none");

        // overflow: 5 bytes into a 4-deep FIFO
        reset_dut();
        rdy_a = 1'b0;
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1);
        tick(20);
        check_val("t5_ovf", ovf_a, exp_ovf_a);
        check_val("t5_err", errc_a, exp_err_a);
        check_val("t5_head", byte_a, 8'h01);
        rdy_a = 1'b1;
        tick(10);
        drain(0, "t5_fifo");
        check_val("t5_vld", vld_a, 0);

        // reset during data bit 4 with a byte pending and ovf/err set
        rdy_a = 1'b0;
        send(0, 8'h11, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1);
        tick(20);
        check_val("t6_pre_vld", vld_a, 1);
        drive(0, 1'b0);
        tick(140 * 5 + 70);
        check_val("t6_pre_busy", busy_a, 1);
        reset_dut();
        check_val("t6_busy", busy_a, 0);
        check_val("t6_vld", vld_a, 0);
        check_val("t6_byte", byte_a, 0);
        check_val("t6_ovf", ovf_a, 0);
        check_val("t6_err", errc_a, 0);
        rdy_a = 1'b1;
        tick(140);
        send(0, 8'h33, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1);
        tick(20);
        drain(0, "t6_byte33");

        // random frames on A, some with a bad stop bit, small timing jitter
        for (int i = 0; i < 12; i++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            send(0, d, 1'b1, st, 1'b1);
            drive(0, 1'b1);
            tick($urandom_range(2, 300));
        end
        tick(200);
        drain(0, "ra_byte");
        check_val("ra_err", errc_a, exp_err_a);
        check_val("ra_frm", nfrm_a, exp_frm_a);
        check_val("ra_ovf", ovf_a, exp_ovf_a);
        check_val("ra_par", npar_a, 0);

        // parity instance
        reset_dut();
        rdy_b = 1'b1;
        send(1, 8'h07, 1'b0, 1'b1, 1'b0);
        drive(1, 1'b1);
        tick(20);
        check_val("p_bad_cnt", npar_b, exp_par_b);
        check_val("p_bad_err", errc_b, exp_err_b);
        drain(1, "p_bad_none");
        send(1, 8'h07, 1'b1, 1'b1, 1'b0);
        drive(1, 1'b1);
        tick(20);
        drain(1, "p_good");
        for (int i = 0; i < 20; i++) begin
            d  = 8'($urandom);
            pk = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 7) != 0);
            send(1, d, pk, st, 1'b0);
            drive(1, 1'b1);
            tick($urandom_range(2, 40));
        end
        tick(50);
        drain(1, "rb_byte");
        check_val("rb_par", npar_b, exp_par_b);
        check_val("rb_frm", nfrm_b, exp_frm_b);
        check_val("rb_err", errc_b, exp_err_b);
        check_val("rb_ovf", ovf_b, exp_ovf_b);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
